// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue
// Purpose  : Collects writeback results from the ALU and the load unit into a
//            small in-order FIFO and drives the register file's single write
//            port, one register write per cycle. Up to two results can be
//            accepted per cycle (ALU first, load second). Results addressed to
//            x0 complete their handshake but are dropped. Per-operand pending
//            flags let decode stall on registers with writes still queued.
// Ports    : clk, rst_n (sync, active-low)
//            aluValid/aluReady/aluAddr/aluData : ALU result handshake
//            memValid/memReady/memAddr/memData : load result handshake
//            RegWrite/WriteAddr/WriteData      : registered write port
//            rs1Addr/rs2Addr -> rs1Pending/rs2Pending : queued-write lookup
//            count                             : FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     aluValid,
  output logic                     aluReady,
  input  logic [ADDR_W-1:0]        aluAddr,
  input  logic [DATA_W-1:0]        aluData,
  input  logic                     memValid,
  output logic                     memReady,
  input  logic [ADDR_W-1:0]        memAddr,
  input  logic [DATA_W-1:0]        memData,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteAddr,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        rs1Addr,
  input  logic [ADDR_W-1:0]        rs2Addr,
  output logic                     rs1Pending,
  output logic                     rs2Pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  // FIFO storage and control state
  logic [ADDR_W-1:0]  r_addr [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;

  // Registered write port
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [DATA_W-1:0]  r_wdata;

  logic [c_cnt_w-1:0] w_free;
  logic               w_alu_push;
  logic               w_mem_push;
  logic               w_pop;
  logic [1:0]         w_npush;
  logic [c_ptr_w-1:0] w_mem_slot;
  logic               w_rs1_hit;
  logic               w_rs2_hit;

  // Readies depend only on registered occupancy and aluValid; a same-edge pop
  // is deliberately not credited, which keeps the ready path short.
  assign w_free   = c_depth - r_count;
  assign aluReady = rst_n && (w_free >= c_cnt_w'(1));
  assign memReady = rst_n && ((w_free >= c_cnt_w'(2)) ||
                              ((w_free >= c_cnt_w'(1)) && !aluValid));

  // x0 results finish the handshake but never occupy a slot.
  assign w_alu_push = aluValid && aluReady && (aluAddr != '0);
  assign w_mem_push = memValid && memReady && (memAddr != '0);
  assign w_npush    = {1'b0, w_alu_push} + {1'b0, w_mem_push};
  assign w_pop      = (r_count != '0);

  // The load lands behind the ALU entry only if the ALU entry was kept.
  assign w_mem_slot = r_tail + c_ptr_w'(w_alu_push);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_tail  <= r_tail + c_ptr_w'(w_npush);
      r_count <= r_count + c_cnt_w'(w_npush) - c_cnt_w'(w_pop);
      r_we    <= w_pop;
      if (w_pop) begin
        r_waddr <= r_addr[r_head];
        r_wdata <= r_data[r_head];
        r_head  <= r_head + c_ptr_w'(1);
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_alu_push) begin
        r_addr[r_tail] <= aluAddr;
        r_data[r_tail] <= aluData;
      end
      if (w_mem_push) begin
        r_addr[w_mem_slot] <= memAddr;
        r_data[w_mem_slot] <= memData;
      end
    end
  end

  // An entry is occupied when its distance from head is below count; the
  // modulo wrap comes for free because DEPTH is a power of two.
  always_comb begin
    logic [c_ptr_w-1:0] w_off;
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    w_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = c_ptr_w'(i) - r_head;
      if ({1'b0, w_off} < r_count) begin
        if (r_addr[i] == rs1Addr) w_rs1_hit = 1'b1;
        if (r_addr[i] == rs2Addr) w_rs2_hit = 1'b1;
      end
    end
  end

  assign rs1Pending = w_rs1_hit && (rs1Addr != '0);
  assign rs2Pending = w_rs2_hit && (rs2Addr != '0);

  assign RegWrite  = r_we;
  assign WriteAddr = r_waddr;
  assign WriteData = r_wdata;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_queue
// Purpose  : Scoreboard bench for writeback_queue. The driver pushes every
//            accepted non-x0 result into a queue; the monitor pops on each
//            port write and compares address/data, occupancy and pending flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              aluValid, memValid;
  logic              aluReady, memReady;
  logic [ADDR_W-1:0] aluAddr, memAddr, WriteAddr, rs1Addr, rs2Addr;
  logic [DATA_W-1:0] aluData, memData, WriteData;
  logic              RegWrite, rs1Pending, rs2Pending;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memAddr(memAddr), .memData(memData),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Pending(rs1Pending), .rs2Pending(rs2Pending), .count(count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   wr_cnt   = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pend(input logic [ADDR_W-1:0] a);
    if (a == '0) return 1'b0;
    foreach (sb[i]) if (sb[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: after each edge the scoreboard holds exactly the FIFO contents
  // once the write now on the port has been popped.
  always @(negedge clk) begin
    if (mon_en) begin
      if (RegWrite === 1'b1) begin
        ent_t e;
        wr_cnt++;
        chk("write_to_x0", 32'(WriteAddr != '0), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", WriteAddr, WriteData);
        end else begin
          e = sb.pop_front();
          chk("wb_addr", 32'(WriteAddr), 32'(e.a));
          chk("wb_data", WriteData, e.d);
        end
      end
      chk("count", 32'(count), 32'(sb.size()));
      chk("rs1Pending", 32'(rs1Pending), 32'(model_pend(rs1Addr)));
      chk("rs2Pending", 32'(rs2Pending), 32'(model_pend(rs2Addr)));
    end
  end

  // One handshake cycle: drive, check readies, record accepted results,
  // then drop valids just after the edge.
  task automatic drive(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       output bit af, output bit mf);
    int fr;
    bit ea, em;
    ent_t e;
    @(negedge clk);
    #1;
    aluValid = av; aluAddr = aa; aluData = ad;
    memValid = mv; memAddr = ma; memData = md;
    #1;
    fr = DEPTH - sb.size();
    ea = rst_n && (fr >= 1);
    em = rst_n && ((fr >= 2) || ((fr >= 1) && !av));
    chk("aluReady", 32'(aluReady), 32'(ea));
    chk("memReady", 32'(memReady), 32'(em));
    af = av && ea;
    mf = mv && em;
    if (af && aa != '0) begin e.a = aa; e.d = ad; sb.push_back(e); end
    if (mf && ma != '0) begin e.a = ma; e.d = md; sb.push_back(e); end
    @(posedge clk);
    #1;
    aluValid = 1'b0;
    memValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || RegWrite === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 40), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit af, mf, ah, mh;
    logic [ADDR_W-1:0] ai, mi;
    int nxt, maxc, cyc, w0;

    rst_n = 1'b0;
    aluValid = 1'b1; aluAddr = 5'd4; aluData = 32'h4;
    memValid = 1'b1; memAddr = 5'd6; memData = 32'h6;
    rs1Addr = '0; rs2Addr = '0;

    // Reset held 3 cycles with both producers requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_aluReady", 32'(aluReady), 32'd0);
      chk("rst_memReady", 32'(memReady), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_RegWrite", 32'(RegWrite), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      mon_en = 1'b1;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    aluValid = 1'b0;
    memValid = 1'b0;

    // Single write: one-cycle latency from acceptance to the port
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, af, mf);
    chk("single_no_early_write", 32'(RegWrite), 32'd0);
    chk("single_count", 32'(count), 32'd1);
    @(posedge clk); #1;
    chk("single_RegWrite", 32'(RegWrite), 32'd1);
    chk("single_addr", 32'(WriteAddr), 32'd5);
    chk("single_data", WriteData, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("single_idle", 32'(RegWrite), 32'd0);
    drain();

    // Dual push: ALU entry first, load entry second
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, af, mf);
    chk("dual_count2", 32'(count), 32'd2);
    @(posedge clk); #1;
    chk("dual_first_addr", 32'(WriteAddr), 32'd1);
    chk("dual_count1", 32'(count), 32'd1);
    @(posedge clk); #1;
    chk("dual_second_addr", 32'(WriteAddr), 32'd2);
    chk("dual_count0", 32'(count), 32'd0);
    @(posedge clk); #1;
    chk("dual_idle", 32'(RegWrite), 32'd0);
    drain();

    // Fill/backpressure: addresses 1..12, each stream holds until accepted.
    // The port drains one entry every non-empty cycle, so occupancy peaks at
    // DEPTH-1 while memReady drops whenever only one slot is free.
    w0 = wr_cnt;
    ai = 5'd1; mi = 5'd2; nxt = 3; ah = 1'b1; mh = 1'b1; maxc = 0; cyc = 0;
    while ((ah || mh) && cyc < 60) begin
      drive(ah, ai, 32'h100 + 32'(ai), mh, mi, 32'h100 + 32'(mi), af, mf);
      cyc++;
      if (int'(count) > maxc) maxc = int'(count);
      if (af) begin
        if (nxt <= 12) begin ai = 5'(nxt); nxt++; end else ah = 1'b0;
      end
      if (mf) begin
        if (nxt <= 12) begin mi = 5'(nxt); nxt++; end else mh = 1'b0;
      end
    end
    chk("fill_all_accepted", 32'(ah || mh), 32'd0);
    chk("fill_peak_count", 32'(maxc), 32'(DEPTH - 1));
    drain();
    chk("fill_write_total", 32'(wr_cnt - w0), 32'd12);

    // x0 filter and pending flags
    @(negedge clk); #1;
    rs1Addr = 5'd3;
    rs2Addr = 5'd0;
    drive(1, 5'd0, 32'hFFFF, 1, 5'd3, 32'h33, af, mf);
    chk("x0_count", 32'(count), 32'd1);
    chk("x0_rs1Pending", 32'(rs1Pending), 32'd1);
    chk("x0_rs2Pending", 32'(rs2Pending), 32'd0);
    drive(1, 5'd7, 32'h77, 0, 5'd0, 32'h0, af, mf);
    chk("x0_port_addr", 32'(WriteAddr), 32'd3);
    chk("x0_port_data", WriteData, 32'h33);
    chk("x0_rs1_cleared", 32'(rs1Pending), 32'd0);
    chk("x0_count_after", 32'(count), 32'd1);
    drain();

    // Reset mid-operation with three entries queued
    drive(1, 5'd9, 32'hA9, 1, 5'd10, 32'hAA, af, mf);
    drive(1, 5'd11, 32'hAB, 1, 5'd12, 32'hAC, af, mf);
    chk("pre_reset_count", 32'(count), 32'd3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_RegWrite", 32'(RegWrite), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale_writes", 32'(wr_cnt - w0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
